// File: rtl/highlight_frame_ctrl.sv
// Per-frame sequencer behind the highlight stage: streams WIDTH*HEIGHT pixels
// FIFO-to-FIFO, counts marker-colour pixels and reports per-frame motion results.
module highlight_frame_ctrl #(
  parameter int          WIDTH      = 720,
  parameter int          HEIGHT     = 540,
  parameter logic [23:0] MARK_COLOR = 24'h0000ff,
  parameter int          THRESH     = 64,
  parameter int          CNT_W      = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [23:0]      in_dout,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [23:0]      out_din,
  output logic [CNT_W-1:0] motion_count,
  output logic             motion_flag,
  output logic [15:0]      frame_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH * HEIGHT - 1);
  localparam logic [CNT_W-1:0] THR_VAL  = CNT_W'(THRESH);

  typedef enum logic [1:0] {IDLE, READ, WRITE, REPORT} state_t;

  state_t           state, state_nxt;
  logic [23:0]      pix_reg;
  logic [CNT_W-1:0] pix_idx;
  logic [CNT_W-1:0] run_cnt;
  logic             last_pix;
  logic             is_mark;

  assign last_pix = (pix_idx == LAST_IDX);
  assign is_mark  = (in_dout == MARK_COLOR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Strobes are combinational so each FIFO handshake completes in the cycle it is offered.
  always_comb begin
    state_nxt = state;
    in_rd_en  = 1'b0;
    out_wr_en = 1'b0;
    out_din   = '0;
    case (state)
      IDLE:   if (start) state_nxt = READ;
      READ: begin
        if (!in_empty) begin
          in_rd_en  = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          out_din   = pix_reg;
          state_nxt = last_pix ? REPORT : READ;
        end
      end
      REPORT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      pix_reg      <= '0;
      pix_idx      <= '0;
      run_cnt      <= '0;
      motion_count <= '0;
      motion_flag  <= 1'b0;
      frame_count  <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pix_idx <= '0;
            run_cnt <= '0;
          end
        end
        READ: begin
          if (in_rd_en) begin
            pix_reg <= in_dout;
            // Saturate rather than wrap so an oversized frame never reports a small count.
            if (is_mark && (run_cnt != '1)) run_cnt <= run_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (out_wr_en && !last_pix) pix_idx <= pix_idx + 1'b1;
        end
        REPORT: begin
          done         <= 1'b1;
          motion_count <= run_cnt;
          motion_flag  <= (run_cnt >= THR_VAL);
          frame_count  <= frame_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
